// File: rtl/dual_debounce.sv
// dual_debounce: two-channel synchroniser + debouncer for the AND stage's a/b inputs.
// Ports: clk, rst_n (async, active-low), a_raw/b_raw in, a/b debounced out,
//   chg one-cycle change strobe (only with `define DUAL_DEBOUNCE_CHG_EN).
module dual_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b
`ifdef DUAL_DEBOUNCE_CHG_EN
  ,
  output logic chg
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [1:0]             out_q;
  logic [1:0]             s;
  logic [1:0]             hit;

  assign raw = {b_raw, a_raw};
  assign a   = out_q[0];
  assign b   = out_q[1];

  // hit: the mismatch has lasted long enough to be accepted this edge
  always_comb begin
    s   = '0;
    hit = '0;
    for (int i = 0; i < 2; i++) begin
      s[i]   = sync_q[i][SYNC_STAGES-1];
      hit[i] = (s[i] != out_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        unique case (1'b1)
          (s[i] == out_q[i]): cnt_q[i] <= '0;
          hit[i]: begin
            cnt_q[i] <= '0;
            out_q[i] <= s[i];
          end
          default: cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        endcase
      end
    end
  end

`ifdef DUAL_DEBOUNCE_CHG_EN
  // one pulse even when both channels flip on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg <= 1'b0;
    else        chg <= |hit;
  end
`endif

endmodule
